// File: rtl/adt7420_i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : adt7420_i2c_target
// Brief    : I2C target emulating the ADT7420 temperature sensor register file.
//            Build macro TEMP_SIM_RAMP_EN swaps temp_i for an internal ramp.
// Revision : 1.0 - initial release
// ============================================================================
module adt7420_i2c_target #(
    parameter logic [6:0]  I2C_ADDR    = 7'h4B,
    parameter int          SYNC_STAGES = 2,
    parameter int          HOLD_CYCLES = 4,
    parameter logic [12:0] T_CRIT      = 13'h930
`ifdef TEMP_SIM_RAMP_EN
   ,parameter int          RAMP_PERIOD = 2000
`endif
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe_o,
    input  logic [12:0] temp_i,
    input  logic        temp_valid_i,
    output logic        ct_o,
    output logic        busy_o,
    output logic [7:0]  cfg_o
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_PTR    = 3'd2,
        S_WRITE  = 3'd3,
        S_READ   = 3'd4,
        S_IGNORE = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             rx_q, rx_d, tx_q, tx_d;
    logic                   rw_q, rw_d, ack_q, ack_d, pend_q, pend_d;
    logic                   hold_act_q, hold_act_d, sda_oe_q, sda_oe_d;
    logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
    logic [7:0]             ptr_q, ptr_d, cfg_q, cfg_d, shadow_q, shadow_d;
    logic [15:0]            temp_q, temp_d;
    logic                   rdyn_q, rdyn_d, ct_q, ct_d, busy_q, busy_d, rd_msb_q, rd_msb_d;

    logic        w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic        w_smp_valid;
    logic [12:0] w_smp;
    logic [15:0] w_src;
    logic [7:0]  w_byte, w_rd_byte;
    logic        w_arm, w_drive, w_load, w_rdyn_set;

`ifdef TEMP_SIM_RAMP_EN
    localparam int RW = $clog2(RAMP_PERIOD);
    logic [RW-1:0] ramp_cnt_q;
    logic [12:0]   ramp_val_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ramp_cnt_q <= '0;
            ramp_val_q <= 13'h190;
        end else if (ramp_cnt_q == RW'(RAMP_PERIOD - 1)) begin
            ramp_cnt_q <= '0;
            ramp_val_q <= (ramp_val_q == 13'h280) ? 13'h190 : ramp_val_q + 13'd8;
        end else begin
            ramp_cnt_q <= ramp_cnt_q + RW'(1);
        end
    end

    assign w_smp_valid = (ramp_cnt_q == RW'(RAMP_PERIOD - 1));
    assign w_smp       = ramp_val_q;
`else
    assign w_smp_valid = temp_valid_i;
    assign w_smp       = temp_i;
`endif

    // Lines idle high, so the synchronizers reset to 1 to avoid phantom edges.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= w_scl;
            sda_prev_q <= w_sda;
        end
    end

    assign w_scl      = scl_sync_q[SYNC_STAGES-1];
    assign w_sda      = sda_sync_q[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~scl_prev_q;
    assign w_scl_fall = ~w_scl & scl_prev_q;
    assign w_start    = scl_prev_q & w_scl & sda_prev_q & ~w_sda;
    assign w_stop     = scl_prev_q & w_scl & ~sda_prev_q & w_sda;
    assign w_byte     = {rx_q, w_sda};
    assign w_src      = w_smp_valid ? {w_smp, 3'b000} : temp_q;

    always_comb begin
        w_rd_byte = 8'h00;
        case (ptr_q)
            8'h00:   w_rd_byte = w_src[15:8];
            8'h01:   w_rd_byte = shadow_q;
            8'h02:   w_rd_byte = {rdyn_q, 7'b0};
            8'h03:   w_rd_byte = cfg_q;
            8'h0B:   w_rd_byte = 8'hCB;
            default: w_rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;    bit_cnt_d  = bit_cnt_q;  rx_d     = rx_q;
        tx_d       = tx_q;       rw_d       = rw_q;       ack_d    = ack_q;
        pend_d     = pend_q;     hold_act_d = hold_act_q; sda_oe_d = sda_oe_q;
        hold_cnt_d = hold_cnt_q; ptr_d      = ptr_q;      cfg_d    = cfg_q;
        shadow_d   = shadow_q;   temp_d     = temp_q;     rdyn_d   = rdyn_q;
        ct_d       = ct_q;       busy_d     = busy_q;     rd_msb_d = rd_msb_q;
        w_arm      = 1'b0;       w_drive    = 1'b0;       w_load   = 1'b0;
        w_rdyn_set = 1'b0;

        if (w_smp_valid) begin
            temp_d = {w_smp, 3'b000};
            ct_d   = ($signed(w_smp) >= $signed(T_CRIT));
        end

        if (hold_act_q) begin
            if (hold_cnt_q == '0) begin
                sda_oe_d   = pend_q;
                hold_act_d = 1'b0;
            end else begin
                hold_cnt_d = hold_cnt_q - HW'(1);
            end
        end

        if (w_start || w_stop) begin
            state_d    = w_start ? S_ADDR : S_IDLE;
            bit_cnt_d  = 4'd0;
            ack_d      = 1'b0;
            busy_d     = 1'b0;
            sda_oe_d   = 1'b0;
            hold_act_d = 1'b0;
        end else if (w_scl_rise && state_q != S_IDLE && state_q != S_IGNORE) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q < 4'd8)
                rx_d = w_byte[6:0];
            if (bit_cnt_q == 4'd7) begin
                case (state_q)
                    S_ADDR: begin
                        if (w_byte[7:1] == I2C_ADDR) begin
                            ack_d  = 1'b1;
                            busy_d = 1'b1;
                            rw_d   = w_sda;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                    S_PTR: begin
                        ptr_d = w_byte;
                        ack_d = 1'b1;
                    end
                    S_WRITE: begin
                        if (ptr_q == 8'h03)
                            cfg_d = w_byte;
                        ptr_d = ptr_q + 8'd1;
                        ack_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (bit_cnt_q == 4'd8 && state_q == S_READ) begin
                w_rdyn_set = rd_msb_q;
                if (w_sda) begin
                    state_d = S_IGNORE;
                    busy_d  = 1'b0;
                end
            end
        end else if (w_scl_fall && state_q != S_IDLE && state_q != S_IGNORE) begin
            if (bit_cnt_q == 4'd8) begin
                w_arm   = 1'b1;
                w_drive = (state_q == S_READ) ? 1'b0 : ack_q;
            end else if (bit_cnt_q == 4'd9) begin
                bit_cnt_d = 4'd0;
                ack_d     = 1'b0;
                w_arm     = 1'b1;
                if (state_q == S_ADDR && !rw_q)
                    state_d = S_PTR;
                else if (state_q == S_PTR)
                    state_d = S_WRITE;
                else if (state_q == S_ADDR || state_q == S_READ) begin
                    state_d = S_READ;
                    w_load  = 1'b1;
                end
            end else if (state_q == S_READ && bit_cnt_q != 4'd0) begin
                w_arm   = 1'b1;
                w_drive = ~tx_q[6];
                tx_d    = {tx_q[5:0], 1'b0};
            end
        end

        // Loading reg 0x00 snapshots the low byte so a later 0x01 read cannot tear.
        if (w_load) begin
            w_drive  = ~w_rd_byte[7];
            tx_d     = w_rd_byte[6:0];
            ptr_d    = ptr_q + 8'd1;
            rd_msb_d = (ptr_q == 8'h00);
            if (ptr_q == 8'h00)
                shadow_d = w_src[7:0];
        end

        if (w_arm) begin
            pend_d     = w_drive;
            hold_cnt_d = HW'(HOLD_CYCLES - 1);
            hold_act_d = 1'b1;
        end

        if (w_smp_valid)
            rdyn_d = 1'b0;
        else if (w_rdyn_set)
            rdyn_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;   bit_cnt_q  <= 4'd0;  rx_q     <= 7'd0;
            tx_q       <= 7'd0;     rw_q       <= 1'b0;  ack_q    <= 1'b0;
            pend_q     <= 1'b0;     hold_act_q <= 1'b0;  sda_oe_q <= 1'b0;
            hold_cnt_q <= '0;       ptr_q      <= 8'h00; cfg_q    <= 8'h00;
            shadow_q   <= 8'h00;    temp_q     <= 16'h0000;
            rdyn_q     <= 1'b1;     ct_q       <= 1'b0;  busy_q   <= 1'b0;
            rd_msb_q   <= 1'b0;
        end else begin
            state_q    <= state_d;    bit_cnt_q  <= bit_cnt_d;  rx_q     <= rx_d;
            tx_q       <= tx_d;       rw_q       <= rw_d;       ack_q    <= ack_d;
            pend_q     <= pend_d;     hold_act_q <= hold_act_d; sda_oe_q <= sda_oe_d;
            hold_cnt_q <= hold_cnt_d; ptr_q      <= ptr_d;      cfg_q    <= cfg_d;
            shadow_q   <= shadow_d;   temp_q     <= temp_d;
            rdyn_q     <= rdyn_d;     ct_q       <= ct_d;       busy_q   <= busy_d;
            rd_msb_q   <= rd_msb_d;
        end
    end

    assign sda_oe_o = sda_oe_q;
    assign ct_o     = ct_q;
    assign busy_o   = busy_q;
    assign cfg_o    = cfg_q;

endmodule
`default_nettype wire

// File: tb/tb_adt7420_i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_adt7420_i2c_target
// Brief    : Directed self-checking bench driving an open-drain I2C master model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adt7420_i2c_target;

    localparam int Q = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic [12:0] temp_i = 13'd0;
    logic        temp_valid_i = 1'b0;
    logic        sda_oe_o, ct_o, busy_o;
    logic [7:0]  cfg_o;
    wire         sda_line = sda_m & ~sda_oe_o;

    int n_chk = 0;
    int n_pass = 0;
    int oe_cnt = 0;
    int busy_cnt = 0;

    adt7420_i2c_target dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .scl_i        (scl_m),
        .sda_i        (sda_line),
        .sda_oe_o     (sda_oe_o),
        .temp_i       (temp_i),
        .temp_valid_i (temp_valid_i),
        .ct_o         (ct_o),
        .busy_o       (busy_o),
        .cfg_o        (cfg_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sda_oe_o) oe_cnt <= oe_cnt + 1;
        if (busy_o)   busy_cnt <= busy_cnt + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start;
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop;
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(Q);
        s = sda_line; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(nack, s);
    endtask

    task automatic strobe(input logic [12:0] v);
        temp_i = v; temp_valid_i = 1'b1;
        tick(1);
        temp_valid_i = 1'b0;
        tick(1);
    endtask

    // Pointer write, repeated START, then read n (1 or 2) bytes; last one NACKed.
    task automatic read_frame(input logic [7:0] ptr, input int n,
                              output logic [15:0] data, output logic ok);
        logic a0, a1, a2;
        logic [7:0] b0, b1;
        bus_start;
        write_byte(8'h96, a0);
        write_byte(ptr, a1);
        bus_start;
        write_byte(8'h97, a2);
        if (n == 2) begin
            read_byte(1'b0, b0);
            read_byte(1'b1, b1);
        end else begin
            read_byte(1'b1, b0);
            b1 = 8'h00;
        end
        bus_stop;
        tick(4);
        data = {b0, b1};
        ok = a0 & a1 & a2;
    endtask

    task automatic test_reset;
        logic a;
        logic ok;
        logic [7:0] d;
        logic [15:0] rd;
        rst = 1'b1; tick(4);
        n_chk++; if (sda_oe_o !== 1'b0) $display("FAIL rst_sda_oe: got %b want 0", sda_oe_o); else n_pass++;
        n_chk++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_o); else n_pass++;
        n_chk++; if (ct_o !== 1'b0) $display("FAIL rst_ct: got %b want 0", ct_o); else n_pass++;
        n_chk++; if (cfg_o !== 8'h00) $display("FAIL rst_cfg: got %h want 00", cfg_o); else n_pass++;
        rst = 1'b0; tick(5);
        bus_start;
        write_byte(8'h97, a);
        read_byte(1'b1, d);
        bus_stop;
        tick(4);
        n_chk++; if (a !== 1'b1) $display("FAIL rst_rd_ack: got %b want 1", a); else n_pass++;
        n_chk++; if (d !== 8'h00) $display("FAIL rst_ptr0_data: got %h want 00", d); else n_pass++;
        read_frame(8'h02, 1, rd, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL rst_status_ack: got %b want 1", ok); else n_pass++;
        n_chk++; if (rd[15:8] !== 8'h80) $display("FAIL rst_status: got %h want 80", rd[15:8]); else n_pass++;
    endtask

    task automatic test_read_temp;
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        strobe(13'h190);
        bus_start;
        write_byte(8'h96, a0);
        write_byte(8'h00, a1);
        bus_start;
        write_byte(8'h97, a2);
        n_chk++; if ({a0, a1, a2} !== 3'b111) $display("FAIL t1_acks: got %b want 111", {a0, a1, a2}); else n_pass++;
        n_chk++; if (busy_o !== 1'b1) $display("FAIL t1_busy_hi: got %b want 1", busy_o); else n_pass++;
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        n_chk++; if (d0 !== 8'h0C) $display("FAIL t1_msb: got %h want 0C", d0); else n_pass++;
        n_chk++; if (d1 !== 8'h80) $display("FAIL t1_lsb: got %h want 80", d1); else n_pass++;
        bus_stop;
        tick(5);
        n_chk++; if (busy_o !== 1'b0) $display("FAIL t1_busy_lo: got %b want 0", busy_o); else n_pass++;
    endtask

    task automatic test_addr_mismatch;
        logic a0, a1;
        int o0, b0;
        o0 = oe_cnt; b0 = busy_cnt;
        bus_start;
        write_byte(8'h90, a0);
        write_byte(8'h00, a1);
        bus_stop;
        tick(4);
        n_chk++; if (a0 !== 1'b0) $display("FAIL t2_nack: got %b want 0", a0); else n_pass++;
        n_chk++; if (oe_cnt !== o0) $display("FAIL t2_sda_quiet: got %0d want %0d", oe_cnt, o0); else n_pass++;
        n_chk++; if (busy_cnt !== b0) $display("FAIL t2_busy_quiet: got %0d want %0d", busy_cnt, b0); else n_pass++;
    endtask

    task automatic test_cfg;
        logic a0, a1, a2, ok;
        logic [15:0] rd;
        bus_start;
        write_byte(8'h96, a0);
        write_byte(8'h03, a1);
        write_byte(8'hA5, a2);
        bus_stop;
        tick(4);
        n_chk++; if (a2 !== 1'b1) $display("FAIL t3_data_ack: got %b want 1", a2); else n_pass++;
        n_chk++; if (cfg_o !== 8'hA5) $display("FAIL t3_cfg_o: got %h want A5", cfg_o); else n_pass++;
        read_frame(8'h03, 1, rd, ok);
        n_chk++; if (rd[15:8] !== 8'hA5 || !ok) $display("FAIL t3_cfg_rd: got %h/%b want A5/1", rd[15:8], ok); else n_pass++;
        read_frame(8'h0B, 1, rd, ok);
        n_chk++; if (rd[15:8] !== 8'hCB) $display("FAIL t3_id: got %h want CB", rd[15:8]); else n_pass++;
        read_frame(8'h07, 1, rd, ok);
        n_chk++; if (rd[15:8] !== 8'h00) $display("FAIL t3_unknown: got %h want 00", rd[15:8]); else n_pass++;
    endtask

    task automatic test_anti_tear;
        logic a0, a1, a2, ok;
        logic [7:0] d0, d1;
        logic [15:0] rd;
        bus_start;
        write_byte(8'h96, a0);
        write_byte(8'h00, a1);
        bus_start;
        write_byte(8'h97, a2);
        read_byte(1'b0, d0);
        strobe(13'h1FF0);
        read_byte(1'b1, d1);
        bus_stop;
        tick(4);
        n_chk++; if (d0 !== 8'h0C) $display("FAIL t4_msb_old: got %h want 0C", d0); else n_pass++;
        n_chk++; if (d1 !== 8'h80) $display("FAIL t4_lsb_shadow: got %h want 80", d1); else n_pass++;
        read_frame(8'h02, 1, rd, ok);
        n_chk++; if (rd[15:8] !== 8'h00) $display("FAIL t4_status_clr: got %h want 00", rd[15:8]); else n_pass++;
        read_frame(8'h00, 2, rd, ok);
        n_chk++; if (rd !== 16'hFF80) $display("FAIL t4_new_temp: got %h want FF80", rd); else n_pass++;
        read_frame(8'h02, 1, rd, ok);
        n_chk++; if (rd[15:8] !== 8'h80) $display("FAIL t4_status_set: got %h want 80", rd[15:8]); else n_pass++;
        strobe(13'h0011);
        bus_start;
        write_byte(8'h96, a0);
        write_byte(8'h00, a1);
        bus_start;
        write_byte(8'h97, a2);
        fork
            read_byte(1'b0, d0);
            begin tick(100); strobe(13'h0022); end
        join
        read_byte(1'b1, d1);
        bus_stop;
        tick(4);
        n_chk++; if ({d0, d1} !== 16'h0088) $display("FAIL t4_no_tear: got %h want 0088", {d0, d1}); else n_pass++;
        read_frame(8'h00, 2, rd, ok);
        n_chk++; if (rd !== 16'h0110) $display("FAIL t4_after_tear: got %h want 0110", rd); else n_pass++;
    endtask

    task automatic test_ct;
        temp_i = 13'h930; temp_valid_i = 1'b1;
        n_chk++; if (ct_o !== 1'b0) $display("FAIL t5_ct_before: got %b want 0", ct_o); else n_pass++;
        tick(1);
        temp_valid_i = 1'b0;
        n_chk++; if (ct_o !== 1'b1) $display("FAIL t5_ct_at_crit: got %b want 1", ct_o); else n_pass++;
        strobe(13'h92F);
        n_chk++; if (ct_o !== 1'b0) $display("FAIL t5_ct_below: got %b want 0", ct_o); else n_pass++;
        strobe(13'h1FF0);
        n_chk++; if (ct_o !== 1'b0) $display("FAIL t5_ct_negative: got %b want 0", ct_o); else n_pass++;
        strobe(13'h0FFF);
        n_chk++; if (ct_o !== 1'b1) $display("FAIL t5_ct_max: got %b want 1", ct_o); else n_pass++;
    endtask

    task automatic test_abort_reset;
        logic a0, a1, a2, s;
        logic [3:0] bits;
        bus_start;
        write_byte(8'h96, a0);
        write_byte(8'h0B, a1);
        bus_start;
        write_byte(8'h97, a2);
        for (int i = 3; i >= 0; i--) begin
            clk_bit(1'b1, s);
            bits[i] = s;
        end
        n_chk++; if (bits !== 4'b1100) $display("FAIL t6_partial_bits: got %b want 1100", bits); else n_pass++;
        bus_start;
        n_chk++; if (sda_oe_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL t6_abort: got oe=%b busy=%b want 0/0", sda_oe_o, busy_o); else n_pass++;
        write_byte(8'h96, a0);
        n_chk++; if (a0 !== 1'b1 || busy_o !== 1'b1)
            $display("FAIL t6_readdress: got ack=%b busy=%b want 1/1", a0, busy_o); else n_pass++;
        for (int i = 7; i >= 0; i--) clk_bit(1'b0, s);
        n_chk++; if (sda_oe_o !== 1'b1) $display("FAIL t6_ack_driven: got %b want 1", sda_oe_o); else n_pass++;
        rst = 1'b1;
        tick(1);
        n_chk++; if (sda_oe_o !== 1'b0 || busy_o !== 1'b0 || cfg_o !== 8'h00)
            $display("FAIL t6_reset: got oe=%b busy=%b cfg=%h want 0/0/00", sda_oe_o, busy_o, cfg_o); else n_pass++;
        rst = 1'b0;
        sda_m = 1'b1; scl_m = 1'b1;
        tick(10);
    endtask

    initial begin
        test_reset;
        test_read_temp;
        test_addr_mismatch;
        test_cfg;
        test_anti_tear;
        test_ct;
        test_abort_reset;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
